// File: rtl/aska_pkg.sv
// Shared types for the ASKA pulse monitor: FSM state encoding and fault bit positions.
package aska_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        PH1,
        IPG,
        PH2,
        REST
    } state_t;

    localparam int FLT_OVERLAP = 0;
    localparam int FLT_IMBAL   = 1;
    localparam int FLT_MISSING = 2;
    localparam int FLT_TIMEOUT = 3;

endpackage

// File: rtl/aska_pulse_monitor_if.sv
// Phase-strobe inputs and measurement-record outputs of the ASKA pulse monitor.
interface aska_pulse_monitor_if #(
    parameter int PW = 12,
    parameter int WW = 8
);
    import aska_pkg::*;

    // No valid/ready pair: meas_valid is a one-cycle strobe with no backpressure,
    // and the record fields stay stable until the next strobe.
    logic          enable;
    logic          phase_c;
    logic          phase_a;
    logic          meas_valid;
    logic [PW-1:0] period;
    logic [WW-1:0] width_c;
    logic [WW-1:0] gap;
    logic [WW-1:0] width_a;
    logic [3:0]    faults;
    logic          fault_sticky;
    state_t        state;
    logic [3:0]    sat;

    modport master (
        output enable, phase_c, phase_a,
        input  meas_valid, period, width_c, gap, width_a, faults, fault_sticky, state, sat
    );

    modport slave (
        input  enable, phase_c, phase_a,
        output meas_valid, period, width_c, gap, width_a, faults, fault_sticky, state, sat
    );

endinterface

// File: rtl/aska_sat_counter.sv
// Saturating up-counter; a clear restarts the count and an increment in the
// same cycle counts that cycle, so the count includes the clearing sample.
module aska_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o,
    output logic         sat_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign sat_o   = &count_q;
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = {{(W-1){1'b0}}, inc_i};
        end else if (inc_i && !sat_o) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/aska_pulse_monitor.sv
// Biphasic pulse monitor: measures period, phase widths and gap per pulse and flags faults.
// Optional ASKA_PM_TIMEOUT_EN: emit a timeout record when the period counter saturates.
module aska_pulse_monitor
    import aska_pkg::*;
#(
    parameter int PW = 12,
    parameter int WW = 8
) (
    input logic                 clk,
    input logic                 resetn,
    aska_pulse_monitor_if.slave mon
);

    state_t        state_q, state_d;
    logic          phase_c_prev_q;
    logic          enable_prev_q;
    logic          overlap_q, overlap_d;
    logic          meas_valid_q;
    logic          fault_sticky_q, sticky_d;
    logic [PW-1:0] period_q;
    logic [WW-1:0] width_c_q, gap_q, width_a_q;
    logic [3:0]    faults_q, faults_d;

    logic          rise, active, pulse_start, clr, emit, timeout_hit, both_low;
    logic          inc_period, inc_wc, inc_gap, inc_wa;
    logic [PW-1:0] period_cnt;
    logic [WW-1:0] wc_cnt, gap_cnt, wa_cnt;
    logic          period_sat, wc_sat, gap_sat, wa_sat;

    always_comb begin
        rise        = mon.phase_c & ~phase_c_prev_q;
        active      = state_q inside {PH1, IPG, PH2, REST};
        pulse_start = mon.enable & rise & (state_q != IDLE);
        clr         = ~mon.enable | ~active | pulse_start;
        both_low    = ~mon.phase_c & ~mon.phase_a;

        // The rise sample belongs to the new pulse, so it never counts toward the old gap/anodic phase.
        inc_period = pulse_start | (mon.enable & active);
        inc_wc     = pulse_start | (mon.enable & (state_q == PH1) & mon.phase_c);
        inc_gap    = mon.enable & ~pulse_start & (state_q inside {PH1, IPG}) & both_low;
        inc_wa     = mon.enable & ~pulse_start & mon.phase_a &
                     (((state_q == PH1) & ~mon.phase_c) | (state_q inside {IPG, PH2}));
    end

    aska_sat_counter #(.W(PW)) u_period (
        .clk(clk), .resetn(resetn), .clr_i(clr), .inc_i(inc_period),
        .count_o(period_cnt), .sat_o(period_sat)
    );
    aska_sat_counter #(.W(WW)) u_width_c (
        .clk(clk), .resetn(resetn), .clr_i(clr), .inc_i(inc_wc),
        .count_o(wc_cnt), .sat_o(wc_sat)
    );
    aska_sat_counter #(.W(WW)) u_gap (
        .clk(clk), .resetn(resetn), .clr_i(clr), .inc_i(inc_gap),
        .count_o(gap_cnt), .sat_o(gap_sat)
    );
    aska_sat_counter #(.W(WW)) u_width_a (
        .clk(clk), .resetn(resetn), .clr_i(clr), .inc_i(inc_wa),
        .count_o(wa_cnt), .sat_o(wa_sat)
    );

    always_comb begin
        state_d     = state_q;
        emit        = 1'b0;
        timeout_hit = 1'b0;
        if (!mon.enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: state_d = WAIT;
                WAIT: if (rise) state_d = PH1;
                PH1:  if (!mon.phase_c) state_d = mon.phase_a ? PH2 : IPG;
                IPG: begin
                    if (rise) begin
                        emit    = 1'b1;
                        state_d = PH1;
                    end else if (mon.phase_a) begin
                        state_d = PH2;
                    end
                end
                PH2: begin
                    if (rise) begin
                        emit    = 1'b1;
                        state_d = PH1;
                    end else if (!mon.phase_a) begin
                        state_d = REST;
                    end
                end
                REST: begin
                    if (rise) begin
                        emit    = 1'b1;
                        state_d = PH1;
                    end
                end
                default: state_d = IDLE;
            endcase
`ifdef ASKA_PM_TIMEOUT_EN
            // A rise in the saturating cycle wins: the pulse record carries the saturated period.
            if (active && period_sat && !rise) begin
                emit        = 1'b1;
                timeout_hit = 1'b1;
                state_d     = WAIT;
            end
`endif
        end

        faults_d              = '0;
        faults_d[FLT_OVERLAP] = overlap_q | (mon.phase_c & mon.phase_a);
        faults_d[FLT_IMBAL]   = (wa_cnt != wc_cnt);
        faults_d[FLT_MISSING] = (wa_cnt == '0);
        faults_d[FLT_TIMEOUT] = timeout_hit;

        overlap_d = overlap_q;
        if (clr) begin
            overlap_d = pulse_start & mon.phase_c & mon.phase_a;
        end else if (active && mon.phase_c && mon.phase_a) begin
            overlap_d = 1'b1;
        end

        sticky_d = fault_sticky_q;
        if (mon.enable && !enable_prev_q) begin
            sticky_d = 1'b0;
        end else if (emit && (|faults_d)) begin
            sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= IDLE;
            phase_c_prev_q <= 1'b0;
            enable_prev_q  <= 1'b0;
            overlap_q      <= 1'b0;
            meas_valid_q   <= 1'b0;
            fault_sticky_q <= 1'b0;
            period_q       <= '0;
            width_c_q      <= '0;
            gap_q          <= '0;
            width_a_q      <= '0;
            faults_q       <= '0;
        end else begin
            state_q        <= state_d;
            phase_c_prev_q <= mon.phase_c;
            enable_prev_q  <= mon.enable;
            overlap_q      <= overlap_d;
            meas_valid_q   <= emit;
            fault_sticky_q <= sticky_d;
            if (emit) begin
                period_q  <= period_cnt;
                width_c_q <= wc_cnt;
                gap_q     <= gap_cnt;
                width_a_q <= wa_cnt;
                faults_q  <= faults_d;
            end
        end
    end

    assign mon.meas_valid   = meas_valid_q;
    assign mon.period       = period_q;
    assign mon.width_c      = width_c_q;
    assign mon.gap          = gap_q;
    assign mon.width_a      = width_a_q;
    assign mon.faults       = faults_q;
    assign mon.fault_sticky = fault_sticky_q;
    assign mon.state        = state_q;
    assign mon.sat          = {wa_sat, gap_sat, wc_sat, period_sat};

endmodule

// File: tb/tb_aska_pulse_monitor.sv
// Directed bench for aska_pulse_monitor: records are captured into a queue and checked per scenario.
module tb_aska_pulse_monitor;
    import aska_pkg::*;

    localparam int PW = 12;
    localparam int WW = 8;
    localparam int RW = PW + 3 * WW + 4;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic [RW-1:0] rec_q[$];
    logic [RW-1:0] nom;
    logic [RW-1:0] r;

    always #5 clk = ~clk;

    aska_pulse_monitor_if #(.PW(PW), .WW(WW)) mon_if ();

    aska_pulse_monitor #(.PW(PW), .WW(WW)) dut (
        .clk(clk),
        .resetn(resetn),
        .mon(mon_if)
    );

    function automatic logic [RW-1:0] mk_rec(input int p, input int wc, input int g, input int wa,
                                             input logic [3:0] f);
        return {PW'(p), WW'(wc), WW'(g), WW'(wa), f};
    endfunction

    function automatic logic [RW-1:0] pop_rec();
        if (rec_q.size() == 0) return 'x;
        return rec_q.pop_front();
    endfunction

    // One input sample: drive, let the DUT clock it, then capture any record it emitted.
    task automatic step(input logic c, input logic a);
        mon_if.phase_c = c;
        mon_if.phase_a = a;
        @(posedge clk);
        #1;
        if (mon_if.meas_valid === 1'b1)
            rec_q.push_back({mon_if.period, mon_if.width_c, mon_if.gap, mon_if.width_a, mon_if.faults});
    endtask

    task automatic drive_pulse(input int wc, input int a_start, input int wa, input int per);
        for (int i = 0; i < per; i++) step(i < wc, (i >= a_start) && (i < a_start + wa));
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        mon_if.enable = 1'b0;
        mon_if.phase_c = 1'b0;
        mon_if.phase_a = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (mon_if.meas_valid !== 1'b0) begin errors++; $display("FAIL reset_meas_valid got=%b want=0", mon_if.meas_valid); end
        checks++; if (mon_if.period !== '0) begin errors++; $display("FAIL reset_period got=%0d want=0", mon_if.period); end
        checks++; if (mon_if.width_c !== '0) begin errors++; $display("FAIL reset_width_c got=%0d want=0", mon_if.width_c); end
        checks++; if (mon_if.gap !== '0) begin errors++; $display("FAIL reset_gap got=%0d want=0", mon_if.gap); end
        checks++; if (mon_if.width_a !== '0) begin errors++; $display("FAIL reset_width_a got=%0d want=0", mon_if.width_a); end
        checks++; if (mon_if.faults !== 4'b0000) begin errors++; $display("FAIL reset_faults got=%b want=0000", mon_if.faults); end
        checks++; if (mon_if.fault_sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky got=%b want=0", mon_if.fault_sticky); end
        checks++; if (mon_if.state !== IDLE) begin errors++; $display("FAIL reset_state got=%0d want=%0d", mon_if.state, IDLE); end
        checks++; if (mon_if.sat !== 4'b0000) begin errors++; $display("FAIL reset_sat got=%b want=0000", mon_if.sat); end
        resetn = 1'b1;
        step(1'b0, 1'b0);
        mon_if.enable = 1'b1;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        checks++; if (mon_if.state !== WAIT) begin errors++; $display("FAIL enable_state got=%0d want=%0d", mon_if.state, WAIT); end
    endtask

    task automatic test_nominal();
        rec_q.delete();
        repeat (3) drive_pulse(10, 12, 10, 100);
        checks++; if (rec_q.size() != 2) begin errors++; $display("FAIL nominal_count got=%0d want=2", rec_q.size()); end
        r = pop_rec();
        checks++; if (r !== nom) begin errors++; $display("FAIL nominal_rec1 got=%h want=%h", r, nom); end
        r = pop_rec();
        checks++; if (r !== nom) begin errors++; $display("FAIL nominal_rec2 got=%h want=%h", r, nom); end
        checks++; if (mon_if.fault_sticky !== 1'b0) begin errors++; $display("FAIL nominal_sticky got=%b want=0", mon_if.fault_sticky); end
        checks++; if (mon_if.state !== REST) begin errors++; $display("FAIL nominal_state got=%0d want=%0d", mon_if.state, REST); end
    endtask

    task automatic test_imbalance();
        logic [RW-1:0] exp_r;
        exp_r = mk_rec(100, 10, 2, 8, 4'b0010);
        rec_q.delete();
        drive_pulse(10, 12, 8, 100);
        drive_pulse(10, 12, 10, 100);
        checks++; if (rec_q.size() != 2) begin errors++; $display("FAIL imbal_count got=%0d want=2", rec_q.size()); end
        r = pop_rec();
        checks++; if (r !== nom) begin errors++; $display("FAIL imbal_prev got=%h want=%h", r, nom); end
        r = pop_rec();
        checks++; if (r !== exp_r) begin errors++; $display("FAIL imbal_rec got=%h want=%h", r, exp_r); end
        checks++; if (mon_if.fault_sticky !== 1'b1) begin errors++; $display("FAIL imbal_sticky got=%b want=1", mon_if.fault_sticky); end
    endtask

    task automatic test_overlap();
        logic [RW-1:0] exp_r;
        exp_r = mk_rec(100, 10, 0, 10, 4'b0001);
        rec_q.delete();
        drive_pulse(10, 9, 11, 100);
        drive_pulse(10, 12, 10, 100);
        checks++; if (rec_q.size() != 2) begin errors++; $display("FAIL overlap_count got=%0d want=2", rec_q.size()); end
        r = pop_rec();
        checks++; if (r !== nom) begin errors++; $display("FAIL overlap_prev got=%h want=%h", r, nom); end
        r = pop_rec();
        checks++; if (r !== exp_r) begin errors++; $display("FAIL overlap_rec got=%h want=%h", r, exp_r); end
    endtask

    task automatic test_missing();
        logic [RW-1:0] exp_r;
        exp_r = mk_rec(50, 10, 40, 0, 4'b0110);
        rec_q.delete();
        drive_pulse(10, 0, 0, 50);
        drive_pulse(10, 12, 10, 100);
        checks++; if (rec_q.size() != 2) begin errors++; $display("FAIL missing_count got=%0d want=2", rec_q.size()); end
        r = pop_rec();
        checks++; if (r !== nom) begin errors++; $display("FAIL missing_prev got=%h want=%h", r, nom); end
        r = pop_rec();
        checks++; if (r !== exp_r) begin errors++; $display("FAIL missing_rec got=%h want=%h", r, exp_r); end
    endtask

    task automatic test_saturation();
        logic [RW-1:0] exp_r;
`ifdef ASKA_PM_TIMEOUT_EN
        exp_r = mk_rec(4095, 10, 2, 10, 4'b1000);
`else
        exp_r = mk_rec(4095, 10, 2, 10, 4'b0000);
`endif
        rec_q.delete();
        drive_pulse(10, 12, 10, 4200);
        drive_pulse(10, 12, 10, 100);
        drive_pulse(10, 12, 10, 100);
        checks++; if (rec_q.size() != 3) begin errors++; $display("FAIL sat_count got=%0d want=3", rec_q.size()); end
        r = pop_rec();
        checks++; if (r !== nom) begin errors++; $display("FAIL sat_prev got=%h want=%h", r, nom); end
        r = pop_rec();
        checks++; if (r !== exp_r) begin errors++; $display("FAIL sat_rec got=%h want=%h", r, exp_r); end
        r = pop_rec();
        checks++; if (r !== nom) begin errors++; $display("FAIL sat_after got=%h want=%h", r, nom); end
    endtask

    task automatic test_disruption();
        // enable dropped in the anodic phase
        drive_pulse(10, 12, 10, 15);
        rec_q.delete();
        mon_if.enable = 1'b0;
        step(1'b0, 1'b1);
        checks++; if (mon_if.state !== IDLE) begin errors++; $display("FAIL dis_en_state got=%0d want=%0d", mon_if.state, IDLE); end
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        checks++; if (rec_q.size() != 0) begin errors++; $display("FAIL dis_en_norec got=%0d want=0", rec_q.size()); end
        checks++; if (mon_if.period !== PW'(100)) begin errors++; $display("FAIL dis_en_hold got=%0d want=100", mon_if.period); end
        mon_if.enable = 1'b1;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        drive_pulse(10, 12, 10, 100);
        checks++; if (rec_q.size() != 0) begin errors++; $display("FAIL dis_en_prime got=%0d want=0", rec_q.size()); end
        checks++; if (mon_if.fault_sticky !== 1'b0) begin errors++; $display("FAIL dis_en_sticky got=%b want=0", mon_if.fault_sticky); end
        drive_pulse(10, 12, 10, 100);
        r = pop_rec();
        checks++; if (r !== nom) begin errors++; $display("FAIL dis_en_resume got=%h want=%h", r, nom); end

        // reset asserted in the anodic phase
        drive_pulse(10, 12, 10, 15);
        rec_q.delete();
        resetn = 1'b0;
        #1;
        checks++; if (mon_if.state !== IDLE) begin errors++; $display("FAIL dis_rst_state got=%0d want=%0d", mon_if.state, IDLE); end
        checks++; if (mon_if.period !== '0) begin errors++; $display("FAIL dis_rst_period got=%0d want=0", mon_if.period); end
        step(1'b0, 1'b1);
        resetn = 1'b1;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        drive_pulse(10, 12, 10, 100);
        checks++; if (rec_q.size() != 0) begin errors++; $display("FAIL dis_rst_prime got=%0d want=0", rec_q.size()); end
        drive_pulse(10, 12, 10, 100);
        checks++; if (rec_q.size() != 1) begin errors++; $display("FAIL dis_rst_count got=%0d want=1", rec_q.size()); end
        r = pop_rec();
        checks++; if (r !== nom) begin errors++; $display("FAIL dis_rst_resume got=%h want=%h", r, nom); end
    endtask

    initial begin
        mon_if.enable  = 1'b0;
        mon_if.phase_c = 1'b0;
        mon_if.phase_a = 1'b0;
        nom = mk_rec(100, 10, 2, 10, 4'b0000);
        test_reset();
        test_nominal();
        test_imbalance();
        test_overlap();
        test_missing();
        test_saturation();
        test_disruption();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
